asc_packet_assembler: RTL and testbench

Byte-to-word packet assembler between the UART protocol handler's ASC byte stream and the scan-chain subsystem. Collects a fixed number of bytes, packs them little-endian into one ADDR_BITS+PAYLOAD_BITS word, and presents address/payload on a valid/ready interface. Partial packets are discarded on `flush`, or optionally after an inter-byte timeout. This gives the scan-chain subsystem a complete, aligned write request instead of raw UART bytes.

---
 rtl/asc_packet_assembler.sv | 143 ++++++++++++++
 tb/tb_asc_packet_assembler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/asc_packet_assembler.sv
// asc_packet_assembler
//   Packs a fixed number of ASC bytes (little-endian) into one
//   ADDR_BITS+PAYLOAD_BITS word and presents it as an address/payload
//   write request for the scan-chain subsystem.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   COLLECT | accepting bytes into slot byte_cnt, in_ready=1
//   PRESENT | full packet held on pkt_addr/pkt_payload, pkt_valid=1
//
//   Optional feature macro: ASC_TIMEOUT_EN
//     defined   - a partial packet is dropped after TIMEOUT_CYCLES idle
//                 cycles, signalled by a one-cycle timeout_err pulse
//     undefined - partial packets are held until completion/flush/reset,
//                 timeout_err is tied low
//
//   Ports
//     clk          system clock
//     n_reset      asynchronous active-low reset
//     flush        synchronous abort of any partial or pending packet
//     in_valid     byte valid from the UART handler
//     in_ready     byte accepted when in_valid && in_ready
//     in_data      byte from the UART handler
//     pkt_valid    assembled packet available
//     pkt_ready    downstream accepts the packet
//     pkt_addr     packet address   (packed bits [ADDR_BITS-1:0])
//     pkt_payload  packet payload   (packed bits above the address)
//     timeout_err  one-cycle pulse when a partial packet times out
//     pkt_count    delivered packet count, wraps modulo 256
module asc_packet_assembler #(
  parameter int ADDR_BITS      = 12,
  parameter int PAYLOAD_BITS   = 160,
  parameter int CLOCK_FREQ     = 100_000_000,
  parameter int TIMEOUT_CYCLES = CLOCK_FREQ / 100
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_data,
  output logic                    pkt_valid,
  input  logic                    pkt_ready,
  output logic [ADDR_BITS-1:0]    pkt_addr,
  output logic [PAYLOAD_BITS-1:0] pkt_payload,
  output logic                    timeout_err,
  output logic [7:0]              pkt_count
);

  localparam int PACKET_BITS  = ADDR_BITS + PAYLOAD_BITS;
  localparam int PACKET_BYTES = (PACKET_BITS + 7) / 8;
  localparam int CNT_W        = (PACKET_BYTES > 1) ? $clog2(PACKET_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(PACKET_BYTES - 1);

  typedef enum logic {COLLECT, PRESENT} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       byte_cnt;
  // Only PACKET_BITS are stored; pad bits of the final byte are dropped.
  logic [PACKET_BITS-1:0] vec;

`ifdef ASC_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  // Expiry fires on the idle cycle that would bring the count to
  // TIMEOUT_CYCLES, so the pulse lands TIMEOUT_CYCLES cycles after the
  // last accepted byte.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_err;
  assign timeout_err = tmo_err;
`else
  assign timeout_err = 1'b0;
`endif

  assign in_ready    = (state == COLLECT);
  assign pkt_valid   = (state == PRESENT);
  assign pkt_addr    = vec[ADDR_BITS-1:0];
  assign pkt_payload = vec[PACKET_BITS-1:ADDR_BITS];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= COLLECT;
      byte_cnt  <= '0;
      vec       <= '0;
      pkt_count <= '0;
`ifdef ASC_TIMEOUT_EN
      tmo_cnt   <= '0;
      tmo_err   <= 1'b0;
`endif
    end else begin
`ifdef ASC_TIMEOUT_EN
      tmo_err <= 1'b0;
`endif
      if (flush) begin
        // Abort wins over byte accept, handshake and timeout alike.
        state    <= COLLECT;
        byte_cnt <= '0;
`ifdef ASC_TIMEOUT_EN
        tmo_cnt  <= '0;
`endif
      end else begin
        case (state)
          COLLECT: begin
            if (in_valid) begin
              for (int i = 0; i < PACKET_BITS; i++) begin
                if (byte_cnt == CNT_W'(i / 8))
                  vec[i] <= in_data[3'(i % 8)];
              end
              if (byte_cnt == LAST_SLOT) begin
                state    <= PRESENT;
                byte_cnt <= '0;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
`ifdef ASC_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end
`ifdef ASC_TIMEOUT_EN
            else if (byte_cnt != '0) begin
              if (tmo_cnt == TMO_LAST) begin
                byte_cnt <= '0;
                tmo_cnt  <= '0;
                tmo_err  <= 1'b1;
              end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
              end
            end
`endif
          end
          PRESENT: begin
            if (pkt_ready) begin
              state     <= COLLECT;
              pkt_count <= pkt_count + 1'b1;
            end
          end
          default: state <= COLLECT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_asc_packet_assembler.sv
module tb_asc_packet_assembler;

  localparam int AB  = 12;
  localparam int PB  = 160;
  localparam int NB  = 22;
  localparam int TMO = 40;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_data = 8'h00;
  logic          pkt_valid;
  logic          pkt_ready = 1'b0;
  logic [AB-1:0] pkt_addr;
  logic [PB-1:0] pkt_payload;
  logic          timeout_err;
  logic [7:0]    pkt_count;

  asc_packet_assembler #(
    .ADDR_BITS(AB), .PAYLOAD_BITS(PB), .CLOCK_FREQ(100_000_000), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .n_reset(n_reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_addr(pkt_addr), .pkt_payload(pkt_payload),
    .timeout_err(timeout_err), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  pb [NB];
  logic [7:0]  exp_cnt = 8'd0;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < NB; i++) pb[i] = base + step * 8'(i);
  endtask

  task automatic send_range(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      in_valid = 1'b1;
      in_data  = pb[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Expected packet from the byte table, independent little-endian packing.
  task automatic check_pkt(input string tag);
    logic [NB*8-1:0] ev;
    for (int i = 0; i < NB; i++) ev[8*i +: 8] = pb[i];
    check({tag, "_valid"}, pkt_valid, 1'b1);
    check({tag, "_addr"}, pkt_addr, ev[AB-1:0]);
    check({tag, "_payload"}, pkt_payload, ev[AB+PB-1:AB]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    #2;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_pkt_valid", pkt_valid, 1'b0);
    check("rst_addr", pkt_addr, '0);
    check("rst_payload", pkt_payload, '0);
    check("rst_count", pkt_count, 8'd0);
    check("rst_tmo", timeout_err, 1'b0);
    #10 n_reset = 1'b1;
    tick();

    // 1: basic packing
    pkt_ready = 1'b1;
    fill(8'h01, 8'h01);
    send_range(0, NB-2);
    check("t1_not_early", pkt_valid, 1'b0);
    send_range(NB-1, NB-1);
    check("t1_in_ready_low", in_ready, 1'b0);
    check("t1_addr_const", pkt_addr, 12'h201);
    check("t1_pay_lo_const", pkt_payload[11:0], 12'h030);
    check_pkt("t1");
    tick();
    exp_cnt++;
    check("t1_one_cycle", pkt_valid, 1'b0);
    check("t1_in_ready_back", in_ready, 1'b1);
    check("t1_count", pkt_count, exp_cnt);

    // 2: backpressure
    pkt_ready = 1'b0;
    fill(8'h30, 8'h07);
    send_range(0, NB-1);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("t2_in_ready", in_ready, 1'b0);
      check("t2_count_hold", pkt_count, exp_cnt);
      check_pkt("t2_stable");
    end
    pkt_ready = 1'b1;
    tick();
    exp_cnt++;
    check("t2_count", pkt_count, exp_cnt);
    check("t2_released", pkt_valid, 1'b0);
    fill(8'hAA, 8'h11);
    send_range(0, NB-1);
    check("t2_slot0", pkt_addr[7:0], 8'hAA);
    check_pkt("t2_next");
    tick();
    exp_cnt++;
    check("t2_count2", pkt_count, exp_cnt);

    // 3: timeout / indefinite hold
`ifdef ASC_TIMEOUT_EN
    begin
      int n;
      fill(8'h21, 8'h01);
      send_range(0, 4);
      n = 0;
      while (timeout_err !== 1'b1 && n < TMO + 20) begin
        tick();
        n++;
      end
      check("t3_tmo_latency", n, TMO);
      tick();
      check("t3_tmo_one_cycle", timeout_err, 1'b0);
      fill(8'h40, 8'h02);
      send_range(0, NB-1);
      check_pkt("t3_after_tmo");
      tick();
      exp_cnt++;
      fill(8'h61, 8'h01);
      send_range(0, 4);
      repeat (TMO-1) tick();
      check("t3_no_early_pulse", timeout_err, 1'b0);
      in_valid = 1'b1;
      in_data  = pb[5];
      tick();
      check("t3_byte_wins", timeout_err, 1'b0);
      send_range(6, NB-1);
      check("t3_no_late_pulse", timeout_err, 1'b0);
      check_pkt("t3_kept");
      tick();
      exp_cnt++;
    end
`else
    fill(8'h21, 8'h01);
    send_range(0, 4);
    for (int c = 0; c < 3*TMO; c++) begin
      tick();
      if (c % TMO == TMO - 1) check("t3_no_tmo", timeout_err, 1'b0);
    end
    check("t3_held_ready", in_ready, 1'b1);
    send_range(5, NB-1);
    check_pkt("t3_held");
    tick();
    exp_cnt++;
`endif
    check("t3_count", pkt_count, exp_cnt);

    // 4: flush
    fill(8'h5A, 8'h03);
    send_range(0, 9);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("t4_no_valid", pkt_valid, 1'b0);
    check("t4_ready", in_ready, 1'b1);
    fill(8'h80, 8'h05);
    send_range(0, NB-1);
    check_pkt("t4_after_flush");
    tick();
    exp_cnt++;
    check("t4_count", pkt_count, exp_cnt);
    pkt_ready = 1'b0;
    fill(8'h11, 8'h13);
    send_range(0, NB-1);
    check("t4_present", pkt_valid, 1'b1);
    flush     = 1'b1;
    pkt_ready = 1'b1;
    tick();
    flush     = 1'b0;
    check("t4_flush_present", pkt_valid, 1'b0);
    check("t4_flush_ready", in_ready, 1'b1);
    check("t4_flush_count", pkt_count, exp_cnt);

    // 5: mid-packet asynchronous reset
    fill(8'h90, 8'h01);
    send_range(0, 6);
    #3 n_reset = 1'b0;
    #1;
    check("t5_in_ready", in_ready, 1'b1);
    check("t5_valid", pkt_valid, 1'b0);
    check("t5_addr", pkt_addr, '0);
    check("t5_payload", pkt_payload, '0);
    check("t5_count", pkt_count, 8'd0);
    check("t5_tmo", timeout_err, 1'b0);
    exp_cnt = 8'd0;
    #10 n_reset = 1'b1;
    tick();
    fill(8'hC3, 8'h07);
    send_range(0, NB-1);
    check_pkt("t5_after_rst");
    tick();
    exp_cnt++;
    check("t5_count_after", pkt_count, exp_cnt);

    // 6: counter wrap (256 packets since reset)
    fill(8'h0F, 8'h0B);
    while (exp_cnt != 8'd255) begin
      send_range(0, NB-1);
      tick();
      exp_cnt++;
    end
    check("t6_count_255", pkt_count, 8'd255);
    send_range(0, NB-1);
    check_pkt("t6_last");
    tick();
    check("t6_count_wrap", pkt_count, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
